ul_fec_sequencer: RTL
=====================

// Module: ul_fec_sequencer
// PURPOSE
// Sequences the uplink FEC decode step between the uplink monitor and the two decoding
// clusters: 16-bit cluster for message-ID frames, 64-bit cluster for message-data frames.
// On each monitor frame-done pulse it selects a cluster and launches it, then bounds the
// decode with a watchdog. It hands clean frames downstream via valid/ready and returns
// ul_fec_done / ul_fec_uncor_err / ul_fec_enc_used to the monitor.
// PARAMETERS
// TIMEOUT_CYCLES  64  max cycles in WAIT_DEC before the decode is declared failed (>=2)
// STAT_WIDTH      16  width of the saturating statistics counters
// PORTS
// clk               in   1   clock
// rst_n             in   1   reset, asynchronous, active-low
// mon_done          in   1   monitor frame-captured pulse (1 cycle)
// mon_enc_used      in   1   monitor frame type: 1 = msg-ID/16-bit, 0 = data/64-bit
// dec0_start        out  1   64-bit cluster start pulse
// dec0_done         in   1   64-bit cluster done pulse
// dec0_uncor_err    in   1   64-bit uncorrectable error; valid with dec0_done
// dec0_cor_err      in   1   64-bit corrected error; valid with dec0_done
// dec1_start/dec1_done/dec1_uncor_err/dec1_cor_err  same set for the 16-bit cluster
// ul_fec_enc_used   out  1   latched cluster select; drives monitor unscramble
// ul_fec_done       out  1   decode-complete pulse to monitor
// ul_fec_uncor_err  out  1   uncorrectable or timeout; valid with ul_fec_done
// out_valid         out  1   decoded frame available downstream
// out_ready         in   1   downstream accept
// out_is_id         out  1   frame type of the offered frame (= ul_fec_enc_used)
// overrun           out  1   sticky: mon_done arrived while busy
// timeout           out  1   sticky: watchdog expired
// stat_ok/stat_cor/stat_uncor  out  STAT_WIDTH  frame counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: ul_fec_enc_used=1; all other outputs 0; state IDLE; timer 0.
// - States and transitions (all outputs registered):
//   IDLE: on mon_done, latch sel<=mon_enc_used into ul_fec_enc_used -> LAUNCH.
//   LAUNCH: dec1_start=1 if sel else dec0_start=1, one cycle; timer<=0 -> WAIT_DEC.
//   WAIT_DEC: timer increments each cycle. Selected done: latch uncor/cor;
//     uncor=0 -> DELIVER, uncor=1 -> REPORT. Timer==TIMEOUT_CYCLES-1 with no done:
//     uncor<=1, timeout<=1 -> REPORT. Done on the same cycle as expiry wins (not a timeout).
//   DELIVER: out_valid=1, held until out_ready. out_is_id is stable while out_valid=1.
//     Transfer cycle -> REPORT.
//   REPORT: ul_fec_done=1 for exactly one cycle, ul_fec_uncor_err=latched uncor -> IDLE.
// - Latency, no error, out_ready tied 1:
//   mon_done@T -> start@T+2 -> dec done@D -> out_valid@D+2 -> ul_fec_done@D+3.
// - Done pulses from the non-selected cluster are ignored in every state.
// - mon_done in any state other than IDLE: dropped, overrun<=1. Only reset clears overrun
//   and timeout.
// - Late done from a timed-out decode arriving in IDLE: ignored.
// - Reset mid-operation returns to IDLE immediately. In-flight start, valid and done are
//   cancelled.
// - ul_fec_enc_used changes only on IDLE+mon_done.
// CONFIGURATION
// UL_FEC_SEQ_STATS_EN defined:
//   - In REPORT, exactly one counter increments: stat_uncor if uncor; else stat_cor if
//     the cor flag is set; else stat_ok.
//   - Counters saturate at all-ones and reset to 0.
// Undefined: stat_* ports tied to 0; no counter flops are inferred.
// TESTING
// 1. mon_done with enc_used=1; dec1_done 5 cycles after start, no err
//    -> out_valid with out_is_id=1; ul_fec_done=1 with uncor_err=0; dec0_start never pulses.
// 2. enc_used=0; dec0_done with uncor=1
//    -> no out_valid; ul_fec_done with ul_fec_uncor_err=1; stat_uncor=1 (STATS_EN).
// 3. enc_used=0; no done for 64 cycles
//    -> timeout=1; ul_fec_uncor_err=1; a dec0_done arriving 10 cycles later is ignored.
// 4. out_ready held low 20 cycles after out_valid
//    -> out_valid and out_is_id stay stable; ul_fec_done pulses 1 cycle after the ready cycle.
// 5. Second mon_done during WAIT_DEC; dec1_done during an enc_used=0 decode
//    -> overrun=1; only the first frame is processed; the foreign done does not end WAIT_DEC.
// 6. rst_n low during DELIVER, then released
//    -> out_valid=0, ul_fec_enc_used=1, stats=0; the next frame completes normally.

Source files
------------

// File: rtl/ul_fec_sequencer.sv
// Uplink FEC decode sequencer: picks the 16-bit (msg-ID) or 64-bit (data) decode
// cluster per monitor frame, launches it, and bounds the decode with a watchdog.
// Clean frames go downstream via valid/ready, and the result is reported back to the monitor.
// Optional statistics counters are built only when UL_FEC_SEQ_STATS_EN is defined.
module ul_fec_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mon_done,
  input  logic                  mon_enc_used,
  output logic                  dec0_start,
  input  logic                  dec0_done,
  input  logic                  dec0_uncor_err,
  input  logic                  dec0_cor_err,
  output logic                  dec1_start,
  input  logic                  dec1_done,
  input  logic                  dec1_uncor_err,
  input  logic                  dec1_cor_err,
  output logic                  ul_fec_enc_used,
  output logic                  ul_fec_done,
  output logic                  ul_fec_uncor_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_id,
  output logic                  overrun,
  output logic                  timeout,
  output logic [STAT_WIDTH-1:0] stat_ok,
  output logic [STAT_WIDTH-1:0] stat_cor,
  output logic [STAT_WIDTH-1:0] stat_uncor
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DEC,
    S_DELIVER,
    S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sel_q, sel_d;
  logic          uncor_q, uncor_d;
  logic          cor_q, cor_d;
  logic          dec0_start_q, dec0_start_d;
  logic          dec1_start_q, dec1_start_d;
  logic          fec_done_q, fec_done_d;
  logic          fec_uncor_q, fec_uncor_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic sel_done;
  logic sel_uncor;
  logic sel_cor;

  // Only the cluster that was launched may end the decode; the other one is muted.
  always_comb begin
    sel_done  = sel_q ? dec1_done      : dec0_done;
    sel_uncor = sel_q ? dec1_uncor_err : dec0_uncor_err;
    sel_cor   = sel_q ? dec1_cor_err   : dec0_cor_err;
  end

  // Next-state and registered-output logic for the decode sequence.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    sel_d        = sel_q;
    uncor_d      = uncor_q;
    cor_d        = cor_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;
    dec0_start_d = 1'b0;
    dec1_start_d = 1'b0;
    fec_done_d   = 1'b0;
    fec_uncor_d  = 1'b0;
    out_valid_d  = 1'b0;

    if (mon_done && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (mon_done) begin
          sel_d   = mon_enc_used;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        dec1_start_d = sel_q;
        dec0_start_d = ~sel_q;
        timer_d      = '0;
        state_d      = S_WAIT_DEC;
      end
      S_WAIT_DEC: begin
        timer_d = timer_q + TW'(1);
        if (sel_done) begin
          uncor_d = sel_uncor;
          cor_d   = sel_cor;
          if (sel_uncor) begin
            fec_done_d  = 1'b1;
            fec_uncor_d = 1'b1;
            state_d     = S_REPORT;
          end else begin
            state_d = S_DELIVER;
          end
        end else if (timer_q == TIMER_LAST) begin
          uncor_d     = 1'b1;
          cor_d       = 1'b0;
          timeout_d   = 1'b1;
          fec_done_d  = 1'b1;
          fec_uncor_d = 1'b1;
          state_d     = S_REPORT;
        end
      end
      S_DELIVER: begin
        if (out_valid_q && out_ready) begin
          fec_done_d  = 1'b1;
          fec_uncor_d = uncor_q;
          state_d     = S_REPORT;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset cancels anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      sel_q        <= 1'b1;
      uncor_q      <= 1'b0;
      cor_q        <= 1'b0;
      dec0_start_q <= 1'b0;
      dec1_start_q <= 1'b0;
      fec_done_q   <= 1'b0;
      fec_uncor_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      uncor_q      <= uncor_d;
      cor_q        <= cor_d;
      dec0_start_q <= dec0_start_d;
      dec1_start_q <= dec1_start_d;
      fec_done_q   <= fec_done_d;
      fec_uncor_q  <= fec_uncor_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign dec0_start       = dec0_start_q;
  assign dec1_start       = dec1_start_q;
  assign ul_fec_enc_used  = sel_q;
  assign ul_fec_done      = fec_done_q;
  assign ul_fec_uncor_err = fec_uncor_q;
  assign out_valid        = out_valid_q;
  assign out_is_id        = sel_q;
  assign overrun          = overrun_q;
  assign timeout          = timeout_q;

`ifdef UL_FEC_SEQ_STATS_EN
  logic [STAT_WIDTH-1:0] stat_ok_q, stat_ok_d;
  logic [STAT_WIDTH-1:0] stat_cor_q, stat_cor_d;
  logic [STAT_WIDTH-1:0] stat_uncor_q, stat_uncor_d;

  // One saturating counter bumps per reported frame, chosen by severity.
  always_comb begin
    stat_ok_d    = stat_ok_q;
    stat_cor_d   = stat_cor_q;
    stat_uncor_d = stat_uncor_q;
    if (state_q == S_REPORT) begin
      if (uncor_q) begin
        if (!(&stat_uncor_q)) stat_uncor_d = stat_uncor_q + STAT_WIDTH'(1);
      end else if (cor_q) begin
        if (!(&stat_cor_q)) stat_cor_d = stat_cor_q + STAT_WIDTH'(1);
      end else begin
        if (!(&stat_ok_q)) stat_ok_d = stat_ok_q + STAT_WIDTH'(1);
      end
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q    <= '0;
      stat_cor_q   <= '0;
      stat_uncor_q <= '0;
    end else begin
      stat_ok_q    <= stat_ok_d;
      stat_cor_q   <= stat_cor_d;
      stat_uncor_q <= stat_uncor_d;
    end
  end

  assign stat_ok    = stat_ok_q;
  assign stat_cor   = stat_cor_q;
  assign stat_uncor = stat_uncor_q;
`else
  assign stat_ok    = '0;
  assign stat_cor   = '0;
  assign stat_uncor = '0;
`endif

endmodule
